interrupt_ctrl_n: RTL
=====================

# interrupt_ctrl_n

Parametrised, memory-mapped interrupt controller that replaces the fixed-source interrupt unit between the peripherals (timer, UART, GPIO, PS/2, SD, USB) and the `riscv_multicyc` external-interrupt inputs. It synchronises `NUM_SRC` request lines and supports per-source enable, edge/level mode and polarity. It tracks one in-service source with a claim/complete handshake and drives `interrupt` and `int_istimer` towards the CPU. The register file sits on the mmapper slave bus (`a`/`d`/`we`/`spo`), in place of the current `int_*` window.

## Interface
Parameters:
- `NUM_SRC`, default 8: number of request inputs, legal range 1..32.
- `TIMER_SRC`, default 0: source index reported as the timer via `int_istimer`. Must be less than `NUM_SRC`.

Ports:
- `clk`  input  1: main clock (`clk_main`).
- `rst`  input  1: reset. Asynchronous, active-low.
- `a`  input  3: register word address.
- `d`  input  32: write data.
- `we`  input  1: write strobe, one cycle per write.
- `spo`  output  32: read data, combinational from `a`.
- `irq_src`  input  NUM_SRC: raw asynchronous requests, bit i is source i.
- `interrupt`  output  1: external interrupt request to the CPU.
- `int_istimer`  output  1: the current winner is `TIMER_SRC`.
- `int_reply`  input  1: one-cycle pulse from the CPU when it takes the interrupt.

## Operation
Register map. Each register is `NUM_SRC` bits wide. Reads zero-extend to 32 bits. Write bits at or above `NUM_SRC` are ignored.
- 0 PENDING: read; write-1-to-clear, which applies to edge-mode bits only.
- 1 ENABLE: read/write.
- 2 MODE: read/write. 1 = edge, 0 = level.
- 3 POLARITY: read/write. 1 = active-low input.
- 4 CLAIM: read returns winner id+1, or 0 if there is no winner. Writing id+1 performs complete.
- 5 CTRL: bit0 = global enable. Other bits read 0.
- 6 INSERVICE: read only. Bits [5:0] = in-service id+1, 0 if none.
- 7 RAW: read only. Synchronised, polarity-corrected inputs.

Input path:
- Two-flop synchroniser per source, then polarity XOR, giving `act`.
- A third register holds the previous `act` for edge detection.

Pending rules:
- Edge mode: a pending bit sets on a 0→1 transition of `act`. It clears on a W1C write or when that source is claimed. If a set and a clear land in the same cycle, the set wins.
- Level mode: the pending bit equals `act`. W1C and claim have no effect on it.

Winner selection:
- Winner = lowest index i with PENDING[i] & ENABLE[i]. Index 0 has the highest priority.

Outputs:
- `interrupt` = CTRL[0] & (INSERVICE == 0) & (a winner exists).
- `int_istimer` = `interrupt` & (winner == `TIMER_SRC`).

State machine (single in-service slot, no nesting):
- IDLE → BUSY: on `int_reply` while `interrupt` = 1. INSERVICE latches winner+1, and the winner's edge pending bit clears.
- An `int_reply` while `interrupt` = 0 is ignored.
- BUSY → IDLE: on a write to CLAIM with a value equal to INSERVICE. A mismatched value, or 0, is ignored.
- Reading CLAIM has no side effects.

Configuration changes:
- Changing MODE, ENABLE or POLARITY while BUSY does not affect INSERVICE.
- Changing POLARITY may itself create an edge.

## Timing
Reset values:
- All registers are 0, and the synchroniser and edge flops are 0.
- `interrupt` = 0 and `int_istimer` = 0.
- `spo` returns 0 for every address.
- Reset asserted mid-operation clears all state immediately, including INSERVICE.

Latencies:
- An input change registered at edge N appears in RAW at N+2. The edge-mode PENDING bit sets at N+3. `interrupt` rises combinationally in the same cycle as PENDING.
- Register writes take effect on the clock edge at which `we` is sampled. `interrupt` reflects the new value in the following cycle.
- `int_reply` sampled at edge M: INSERVICE becomes valid and `interrupt` falls after M.
- A CLAIM complete at edge K lets `interrupt` reassert in cycle K+1 if another request is pending.
- An `int_reply` and a CLAIM write in the same cycle: the complete is processed first, then the reply is evaluated against the pre-edge `interrupt`. This is equivalent to a reply seen with BUSY, so the reply is ignored.

## Test plan
- Reset behaviour: `rst` = 0, then released → every register reads 0x0 and `interrupt` = 0. Assert `rst` mid-BUSY → INSERVICE reads 0 immediately.
- Edge claim and complete: ENABLE=0x04, MODE=0x04, CTRL=1; pulse `irq_src[2]` for 1 cycle → PENDING=0x04 at +3 cycles, `interrupt`=1, CLAIM reads 3. Pulse `int_reply` → `interrupt`=0, PENDING=0, INSERVICE=3. Write CLAIM=3 → INSERVICE=0.
- Priority and timer flag: level mode, ENABLE=0xFF, hold `irq_src`=0x81 → CLAIM reads 1 and `int_istimer`=1. Disable bit 0 → CLAIM reads 8 and `int_istimer`=0.
- Wrong complete: BUSY with INSERVICE=3; write CLAIM=5 → INSERVICE stays 3 and `interrupt` stays 0. A second edge on source 2 while BUSY → PENDING=0x04, with `interrupt` reasserting one cycle after the correct complete.
- W1C collision and polarity: write PENDING=0x02 in the same cycle a source-1 edge sets it → PENDING[1] stays 1. POLARITY=0x10 with `irq_src[4]`=0 → RAW=0x10, and level-mode PENDING[4]=1.
- `NUM_SRC`=32 build: request on source 31 only → CLAIM reads 32. Writing 0xFFFFFFFF to ENABLE reads back 0xFFFFFFFF. With `NUM_SRC`=3, ENABLE reads back 0x7.

Source files
------------

// File: rtl/interrupt_ctrl_n.sv
// interrupt_ctrl_n: memory-mapped interrupt controller.
// NUM_SRC request lines are synchronised, polarity-corrected and latched
// (edge mode) or passed through (level mode). The lowest enabled pending
// index wins. A single in-service slot is tracked with a claim/complete
// handshake: the CPU takes the interrupt with int_reply and releases it by
// writing id+1 to CLAIM.
module interrupt_ctrl_n #(
  parameter int NUM_SRC   = 8,
  parameter int TIMER_SRC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         a,
  input  logic [31:0]        d,
  input  logic               we,
  output logic [31:0]        spo,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               interrupt,
  output logic               int_istimer,
  input  logic               int_reply
);

  localparam logic [2:0] ADDR_PEND  = 3'd0;
  localparam logic [2:0] ADDR_EN    = 3'd1;
  localparam logic [2:0] ADDR_MODE  = 3'd2;
  localparam logic [2:0] ADDR_POL   = 3'd3;
  localparam logic [2:0] ADDR_CLAIM = 3'd4;
  localparam logic [2:0] ADDR_CTRL  = 3'd5;
  localparam logic [2:0] ADDR_INSVC = 3'd6;
  localparam logic [2:0] ADDR_RAW   = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Input path and configuration state
  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q, mode_q, pol_q;
  logic               ctrl_q;
  logic [5:0]         insvc_q, insvc_d;
  state_t             state_q, state_d;

  // Derived combinational signals
  logic [NUM_SRC-1:0] act;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] cand;
  logic [4:0]         win_id;
  logic               win_valid;
  logic               accept;
  logic               complete;
  logic               wr_pend;

  assign act      = sync2_q ^ pol_q;
  assign edge_det = act & ~prev_q;
  // Level-mode bits mirror the input directly; edge-mode bits come from the latch.
  assign pending  = (mode_q & pend_q) | (~mode_q & act);
  assign cand     = pending & en_q;
  assign wr_pend  = we && (a == ADDR_PEND);
  // A complete only counts while busy and with the exact in-service id+1.
  assign complete = we && (a == ADDR_CLAIM) && (state_q == ST_BUSY) &&
                    (d == {26'd0, insvc_q});

  // Priority encoder: scan downwards so the lowest index is the last to win.
  always_comb begin
    win_id    = 5'd0;
    win_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_id    = 5'(i);
        win_valid = 1'b1;
      end
    end
  end

  assign interrupt   = ctrl_q && (insvc_q == 6'd0) && win_valid;
  assign int_istimer = interrupt && (win_id == 5'(TIMER_SRC));

  // Per-source edge pending: set beats W1C/claim clear; level bits are held at 0.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pend
    logic clr_bit;
    assign clr_bit    = (wr_pend && d[gi]) || (accept && (win_id == 5'(gi)));
    assign pend_d[gi] = mode_q[gi] & (edge_det[gi] | (pend_q[gi] & ~clr_bit));
  end

  // Claim/complete handshake: next-state and in-service slot update.
  always_comb begin
    state_d = state_q;
    insvc_d = insvc_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (int_reply && interrupt) begin
          state_d = ST_BUSY;
          insvc_d = {1'b0, win_id} + 6'd1;
          accept  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (complete) begin
          state_d = ST_IDLE;
          insvc_d = 6'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        insvc_d = 6'd0;
      end
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      insvc_q <= 6'd0;
    end else begin
      state_q <= state_d;
      insvc_q <= insvc_d;
    end
  end

  // Two-flop synchroniser, previous-act flop and edge pending latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
      prev_q  <= act;
      pend_q  <= pend_d;
    end
  end

  // Configuration registers; bits above NUM_SRC are dropped on write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      ctrl_q <= 1'b0;
    end else if (we) begin
      case (a)
        ADDR_EN:   en_q   <= d[NUM_SRC-1:0];
        ADDR_MODE: mode_q <= d[NUM_SRC-1:0];
        ADDR_POL:  pol_q  <= d[NUM_SRC-1:0];
        ADDR_CTRL: ctrl_q <= d[0];
        default:   ;
      endcase
    end
  end

  // Read mux, combinational from the address; narrow registers zero-extend.
  always_comb begin
    spo = 32'd0;
    case (a)
      ADDR_PEND:  spo = 32'(pending);
      ADDR_EN:    spo = 32'(en_q);
      ADDR_MODE:  spo = 32'(mode_q);
      ADDR_POL:   spo = 32'(pol_q);
      ADDR_CLAIM: spo = win_valid ? 32'({1'b0, win_id} + 6'd1) : 32'd0;
      ADDR_CTRL:  spo = {31'd0, ctrl_q};
      ADDR_INSVC: spo = {26'd0, insvc_q};
      ADDR_RAW:   spo = 32'(act);
      default:    spo = 32'd0;
    endcase
  end

endmodule
